// File: rtl/tdm_demux_pkg.sv
// Shared TDM framing constants, also used by the sending-side TDM block.
// Optional parity slot is enabled by defining TDM_PARITY_EN (undefined by default).
package tdm_demux_pkg;

  localparam int N_DEF  = 8;
  localparam int SW_DEF = 4;

  // Index of the final slot in a frame; the parity build adds one slot after the data.
  function automatic int slot_last(input int n);
`ifdef TDM_PARITY_EN
    return n;
`else
    return n - 1;
`endif
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Enable/sync/wrap slot counter shared by the TDM receiver and transmitter.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int SW   = SW_DEF,
  parameter int LAST = N_DEF - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  output logic [SW-1:0] cnt,
  output logic          last,
  output logic          trunc
);

  assign last  = (cnt == SW'(LAST));
  // A sync arriving anywhere but slot 0 cuts off a partial frame.
  assign trunc = sync && (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (sync)      cnt <= SW'(1);
      else if (last) cnt <= '0;
      else           cnt <= cnt + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Serial-to-parallel TDM demultiplexer: assembles slots into a frame word with a valid strobe.
// Define TDM_PARITY_EN for an extra even-parity slot per frame and a par_err flag.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          frame_sync,
  input  logic          i,
  output logic [SW-1:0] s,
  output logic [N-1:0]  o,
  output logic          valid,
  output logic          sync_err,
  output logic          par_err
);

  localparam int LAST = slot_last(N);

  logic [SW-1:0] cnt;
  logic          last;
  logic          trunc;
  logic [N-1:0]  shadow;

  tdm_slot_counter #(.SW(SW), .LAST(LAST)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .sync  (frame_sync),
    .cnt   (cnt),
    .last  (last),
    .trunc (trunc)
  );

  assign s = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      o        <= '0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
`ifdef TDM_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      valid    <= 1'b0;
      sync_err <= 1'b0;
      if (en) begin
        if (frame_sync) begin
          // Sync bit is slot 0 of the new frame; any partial frame is dropped.
          shadow   <= {{(N-1){1'b0}}, i};
          sync_err <= trunc;
        end else if (last) begin
          valid <= 1'b1;
`ifdef TDM_PARITY_EN
          o       <= shadow;
          par_err <= (^shadow) ^ i;
`else
          o        <= shadow;
          o[N-1]   <= i;
`endif
        end else begin
          for (int k = 0; k < N; k++)
            if (cnt == SW'(k)) shadow[k] <= i;
        end
      end
    end
  end

`ifndef TDM_PARITY_EN
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed + random bench for tdm_demux against a queue-based frame model.
// Works in both the default and TDM_PARITY_EN builds.
module tb_tdm_demux;
  localparam int N  = 8;
  localparam int SW = 4;
`ifdef TDM_PARITY_EN
  localparam int FLEN = N + 1;
`else
  localparam int FLEN = N;
`endif

  logic          clk = 1'b0;
  logic          rst, en, frame_sync, i;
  logic [SW-1:0] s;
  logic [N-1:0]  o;
  logic          valid, sync_err, par_err;

  tdm_demux #(.N(N), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frame_sync (frame_sync),
    .i          (i),
    .s          (s),
    .o          (o),
    .valid      (valid),
    .sync_err   (sync_err),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  // Model: bits received so far in the current frame, plus last reported outputs.
  bit          q[$];
  logic [N-1:0] m_o;
  logic        m_valid, m_se, m_pe;
  int          n_assert = 0;
  int          fails    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic f, input logic d);
    m_valid = 1'b0;
    m_se    = 1'b0;
    if (r) begin
      q.delete();
      m_o  = '0;
      m_pe = 1'b0;
    end else if (e) begin
      if (f) begin
        m_se = (q.size() != 0);
        q.delete();
        q.push_back(d);
      end else begin
        q.push_back(d);
        if (q.size() == FLEN) begin
          for (int k = 0; k < N; k++) m_o[k] = q[k];
          m_valid = 1'b1;
`ifdef TDM_PARITY_EN
          m_pe = (^m_o) ^ q[N];
`endif
          q.delete();
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic f, input logic d);
    rst = r; en = e; frame_sync = f; i = d;
    @(posedge clk);
    model(r, e, f, d);
    #1;
    chk("s", 32'(s), 32'(q.size()));
    chk("o", 32'(o), 32'(m_o));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("sync_err", 32'(sync_err), 32'(m_se));
    chk("par_err", 32'(par_err), 32'(m_pe));
  endtask

  // Sends one full frame; optional en=0 gap after slot gap_at, optional wrong parity.
  task automatic send_frame(input logic [N-1:0] data, input logic sync,
                            input int gap_at, input int gap_len, input logic par_flip);
    for (int k = 0; k < FLEN; k++) begin
      step(1'b0, 1'b1, sync && (k == 0), (k < N) ? data[k] : ((^data) ^ par_flip));
      if (k == gap_at)
        for (int g = 0; g < gap_len; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    m_o = '0; m_valid = 1'b0; m_se = 1'b0; m_pe = 1'b0;
    rst = 1'b1; en = 1'b1; frame_sync = 1'b0; i = 1'b1;

    // Reset with en and i active.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_o", 32'(o), 32'h0);
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);

    // Basic capture: 1,0,1,1,0,0,1,0 -> 0x4D.
    send_frame(8'h4D, 1'b1, -1, 0, 1'b0);
    chk("cap_o", 32'(o), 32'h4D);
    chk("cap_valid", 32'(valid), 32'h1);
    chk("cap_s", 32'(s), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("cap_valid_drop", 32'(valid), 32'h0);

    // Enable gap of 3 after slot 3: s holds at 4.
    send_frame(8'h4D, 1'b1, 3, 3, 1'b0);
    chk("gap_o", 32'(o), 32'h4D);

    // Truncation at s=5, then complete a 0xFF frame from slot 1.
    send_frame(8'h12, 1'b1, -1, 0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, k == 0, 1'b0);
    chk("trunc_pre_s", 32'(s), 32'h5);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("trunc_se", 32'(sync_err), 32'h1);
    chk("trunc_s", 32'(s), 32'h1);
    chk("trunc_o", 32'(o), 32'h12);
    chk("trunc_valid", 32'(valid), 32'h0);
    for (int k = 1; k < FLEN; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("ff_o", 32'(o), 32'hFF);

    // Sync exactly at the last slot wins over completion.
    for (int k = 0; k < FLEN - 1; k++) step(1'b0, 1'b1, k == 0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("lastsync_valid", 32'(valid), 32'h0);
    chk("lastsync_se", 32'(sync_err), 32'h1);
    chk("lastsync_o", 32'(o), 32'hFF);

    // Back-to-back frames, sync only on the first.
    send_frame(8'hA5, 1'b1, -1, 0, 1'b0);
    chk("b2b_o1", 32'(o), 32'hA5);
    send_frame(8'h3C, 1'b0, -1, 0, 1'b0);
    chk("b2b_o2", 32'(o), 32'h3C);
    chk("b2b_valid2", 32'(valid), 32'h1);

`ifdef TDM_PARITY_EN
    send_frame(8'h4D, 1'b1, -1, 0, 1'b0);
    chk("par_ok", 32'(par_err), 32'h0);
    send_frame(8'h4D, 1'b1, -1, 0, 1'b1);
    chk("par_bad", 32'(par_err), 32'h1);
    chk("par_bad_valid", 32'(valid), 32'h1);
`else
    chk("par_tied", 32'(par_err), 32'h0);
`endif

    // Random traffic.
    for (int c = 0; c < 400; c++)
      step(($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 10) == 0, 1'($urandom % 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: receives one serial bit per enabled clock on `i` and steers it to channel slot `s`.
- Collects N slots into a frame and presents them as a parallel word `o[N-1:0]` with a one-cycle `valid` strobe.
- Receiving end of an 8:1 select-and-forward path. Slot k of the frame corresponds to select value k on the sending side.

Parameters:
- N, 8, number of channels (frame width in data slots); 2..16.
- SW, 4, slot counter width; must satisfy 2^SW >= N+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  slot enable; when low, all state holds.
- frame_sync  input  1  marks the current `i` bit as slot 0 of a new frame; qualified by `en`.
- i  input  1  serial data bit for the current slot.
- s  output  SW  current slot index (registered counter value).
- o  output  N  last completed frame; bit k = slot k.
- valid  output  1  one-cycle pulse, high in the cycle after a frame completes.
- sync_err  output  1  one-cycle pulse, high when `frame_sync` truncates a partial frame.
- par_err  output  1  parity mismatch flag, qualified by `valid`. Tied to 0 when the feature is out.

Behaviour:
- Reset (rst=1 at a clk edge): cnt=0, shadow=0, o=0, valid=0, sync_err=0, par_err=0. Reset has priority over all other inputs and aborts any partial frame.
- `s` = cnt. Internal shadow register has N bits.
- `valid` and `sync_err` default to 0 every cycle; each is high for exactly one cycle when set.
- en=0: cnt, shadow and o hold; valid and sync_err are 0.
- en=1, frame_sync=1:
  - shadow <= {0…, i}; cnt <= 1.
  - sync_err <= 1 if cnt != 0, otherwise 0.
  - No valid pulse. `o` is unchanged; the partial frame is discarded.
- en=1, frame_sync=0, cnt < LAST: shadow[cnt] <= i; cnt <= cnt+1.
- en=1, frame_sync=0, cnt == LAST (frame complete):
  - o <= shadow with slot LAST written from `i` (in the no-parity build).
  - valid <= 1; cnt <= 0.
- LAST = N-1 without the feature; N with the feature.
- Latency: the final slot bit is sampled at edge k; the new `o` and `valid` are visible after edge k. That is 1 cycle from last bit to output.
- Simultaneous frame_sync with cnt==LAST: sync wins. No valid, sync_err=1, cnt <= 1.
- Free-running without frame_sync: cnt wraps LAST -> 0 and frames are back-to-back with no idle slot.
- `o` changes only on frame completion or reset.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - Each frame carries N+1 slots; slot N is an even-parity bit over the N data bits.
  - On completion, o <= data bits.
  - par_err <= (XOR of data bits) XOR i, updated together with valid and held until the next completion or reset.
- Undefined: frames are N slots; par_err is constant 0; no parity logic is synthesised.

Decomposition:
- Shared include file holds:
  - Default N and SW.
  - Slot-count helper define (LAST as a function of N and the parity macro).
  - The TDM_PARITY_EN default (undefined).
- The same file is used by the sending-side TDM block.
- One natural sub-module: `tdm_slot_counter`. Enable/sync/wrap counter that outputs cnt, a `last` flag and a `trunc` flag; reused by the transmitter.
- Shift/assembly logic and output registers stay in tdm_demux.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with en=1 and i=1 -> o=0x00, s=0, valid=0, sync_err=0.
2. Frame capture: en=1, frame_sync on slot 0, i serial = 1,0,1,1,0,0,1,0 (slots 0..7) -> after the 8th edge o=0x4D, valid high for exactly 1 cycle, s=0.
3. Enable gaps: same frame with en=0 inserted for 3 cycles after slot 3 -> o=0x4D. valid appears 3 cycles later; s holds at 4 during the gap.
4. Truncation: frame_sync asserted at s=5 -> sync_err=1 for 1 cycle, no valid, o keeps its previous value, s=1. A following full frame 0xFF -> o=0xFF.
5. Back-to-back: two frames 0xA5 then 0x3C with no idle slot and frame_sync only on the first -> valid pulses exactly 8 cycles apart, with o=0xA5 then o=0x3C.
6. TDM_PARITY_EN build: frame 0x4D (four ones) with parity slot 0 -> par_err=0. Same data with parity slot 1 -> par_err=1 with valid. `s` reaches 8 before wrap.
